// File: rtl/shift_count_ctrl_pkg.sv
// State encodings and nominal shift count shared by the sequencing FSM and its bench.
// One operation clears the down counter, loads the datapath, then shifts until the counter's carry.
package shift_count_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // A freshly cleared 3-bit down counter raises co on its 8th enabled count.
  localparam int SHIFTS = 8;

endpackage

// File: rtl/shift_count_ctrl.sv
// Sequencer: CLR, LOAD, SHIFT until co, DONE; start-to-done is 11 cycles plus one per stalled SHIFT cycle.
// stall freezes shifting in SHIFT only; start is sampled in IDLE alone, so requests while busy are dropped.
module shift_count_ctrl
  import shift_count_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stall,
  input  logic co,
  output logic cnt,
  output logic ctr_clr,
  output logic ld,
  output logic sh,
  output logic busy,
  output logic done
);

  logic [2:0] state_q;
  logic [2:0] state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stall has priority over co: a frozen cycle never completes the operation.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
        else       state_d = S_IDLE;
      end
      S_CLR:   state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (stall)   state_d = S_SHIFT;
        else if (co) state_d = S_DONE;
        else         state_d = S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode state only (plus stall), so X on start/co cannot reach them.
  always_comb begin
    ctr_clr = (state_q == S_CLR);
    ld      = (state_q == S_LOAD);
    cnt     = (state_q == S_SHIFT) && !stall;
    sh      = cnt;
    done    = (state_q == S_DONE);
    busy    = (state_q == S_CLR) || (state_q == S_LOAD) ||
              (state_q == S_SHIFT) || (state_q == S_DONE);
  end

endmodule

// File: tb/tb_shift_count_ctrl.sv
// Directed bench with a behavioural down-counter model and a per-cycle expected-output scoreboard.
module tb_shift_count_ctrl;
  import shift_count_ctrl_pkg::*;

  logic clk, rst, start, stall, co, co_force;
  logic cnt, ctr_clr, ld, sh, busy, done;
  logic [2:0] cnt_m;

  // Output vector layout: {busy, ctr_clr, ld, cnt, sh, done}
  localparam logic [5:0] V_IDLE  = 6'b000000;
  localparam logic [5:0] V_CLR   = 6'b110000;
  localparam logic [5:0] V_LOAD  = 6'b101000;
  localparam logic [5:0] V_SHIFT = 6'b100110;
  localparam logic [5:0] V_STALL = 6'b100000;
  localparam logic [5:0] V_DONE  = 6'b100001;

  typedef struct {
    logic [5:0] v;
    int         cyc;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  int    n_sh  = 0;
  int    n_done = 0;
  int    pcyc  = 0;
  string tname = "init";

  shift_count_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stall   (stall),
    .co      (co),
    .cnt     (cnt),
    .ctr_clr (ctr_clr),
    .ld      (ld),
    .sh      (sh),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Down counter: cleared to 0, counts 0,7,6,...,1 -> carry on the 8th enabled count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt_m <= 3'd0;
    else if (ctr_clr) cnt_m <= 3'd0;
    else if (cnt)    cnt_m <= cnt_m - 3'd1;
  end
  assign co = co_force | (cnt & (cnt_m == 3'd1));

  function automatic logic [5:0] obs_vec();
    return {busy, ctr_clr, ld, cnt, sh, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tname, tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] v);
    exp_t e;
    pcyc++;
    e.v = v;
    e.cyc = pcyc;
    sb.push_back(e);
  endtask

  // One full operation from CLR to DONE; cycles stall_at..stall_at+stall_len-1 are frozen.
  task automatic push_op(input int stall_at, input int stall_len);
    int n = 0;
    push(V_CLR);
    push(V_LOAD);
    while (n < SHIFTS) begin
      if (pcyc + 1 >= stall_at && pcyc + 1 < stall_at + stall_len) push(V_STALL);
      else begin
        push(V_SHIFT);
        n++;
      end
    end
    push(V_DONE);
  endtask

  // start is sampled at this edge; stall/co_force apply to the cycle that follows, which is checked.
  task automatic tick(input logic st, input logic sl, input logic cf);
    exp_t e;
    start = st;
    @(posedge clk);
    #1;
    stall = sl;
    co_force = cf;
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("cyc%0d", e.cyc), {26'd0, obs_vec()}, {26'd0, e.v});
    end
    if (sh) n_sh++;
    if (done) n_done++;
  endtask

  task automatic run(input int n, input logic [63:0] sp, input logic [63:0] slp,
                     input logic [63:0] cfp);
    for (int c = 1; c <= n; c++) tick(sp[c], slp[c], cfp[c]);
    start = 1'b0;
    stall = 1'b0;
    co_force = 1'b0;
  endtask

  task automatic begin_test(input string name);
    tname = name;
    pcyc = 0;
    n_sh = 0;
    n_done = 0;
  endtask

  // Asynchronous reset mid-cycle: outputs must drop before the next edge.
  task automatic reset_pulse();
    #2 rst = 1'b0;
    #1 chk("async_rst", {26'd0, obs_vec()}, {26'd0, V_IDLE});
    #3 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    co_force = 1'b0;
    #1 chk("reset_state", {26'd0, obs_vec()}, {26'd0, V_IDLE});
    #20 rst = 1'b1;

    begin_test("reset_idle");
    push(V_CLR);
    run(1, 64'h2, 64'h0, 64'h0);
    reset_pulse();
    pcyc = 0;
    for (int i = 0; i < 5; i++) push(V_IDLE);
    run(5, 64'h0, 64'h0, 64'h0);

    begin_test("nominal");
    push_op(0, 0);
    push(V_IDLE);
    run(12, 64'h2, 64'h0, 64'h0);
    chk("shifts", n_sh, SHIFTS);
    chk("dones", n_done, 1);

    begin_test("stall");
    push_op(10, 3);
    push(V_IDLE);
    run(15, 64'h2, 64'h1C00, 64'h400);
    chk("shifts", n_sh, SHIFTS);
    chk("dones", n_done, 1);

    begin_test("start_busy");
    push_op(0, 0);
    push(V_IDLE);
    push(V_IDLE);
    run(13, 64'h1022, 64'h0, 64'h0);
    chk("dones", n_done, 1);

    begin_test("start_held");
    push_op(0, 0);
    push(V_IDLE);
    push_op(0, 0);
    push(V_IDLE);
    run(24, 64'h3FFE, 64'h0, 64'h0);
    chk("shifts", n_sh, 2 * SHIFTS);
    chk("dones", n_done, 2);

    begin_test("rst_mid_shift");
    push(V_CLR);
    push(V_LOAD);
    for (int i = 0; i < 4; i++) push(V_SHIFT);
    run(6, 64'h2, 64'h0, 64'h0);
    reset_pulse();
    chk("dones_before", n_done, 0);
    pcyc = 0;
    n_sh = 0;
    push_op(0, 0);
    push(V_IDLE);
    run(12, 64'h2, 64'h0, 64'h0);
    chk("shifts", n_sh, SHIFTS);
    chk("dones", n_done, 1);

    begin_test("spurious_co");
    push(V_IDLE);
    push(V_IDLE);
    push_op(0, 0);
    push(V_IDLE);
    run(14, 64'h8, 64'h0, 64'h1E);
    chk("shifts", n_sh, SHIFTS);
    chk("dones", n_done, 1);

    tname = "end";
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
